// File: rtl/parity_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : parity_frame_gen                                                |
// | Brief    : folds a valid/ready word stream into one even/odd parity bit    |
// |            per frame; define PARITY_CHECK_EN to add a receive-side checker |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module parity_frame_gen #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int BW        = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [BW-1:0]    out_beats,
    output logic             ovf_err
`ifdef PARITY_CHECK_EN
    ,
    input  logic             in_parity,
    output logic             chk_err,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_ACC  = 2'd1;
    localparam logic [1:0]    c_HOLD = 2'd2;
    localparam logic [BW-1:0] c_MAX  = BW'(MAX_BEATS);
    localparam logic [BW-1:0] c_ONE  = BW'(1);

    logic [1:0]    r_state, w_state_nxt;
    logic          r_acc, w_acc_nxt;
    logic [BW-1:0] r_count, w_count_nxt;
    logic          r_mode, w_mode_nxt;
    logic          r_out_valid, w_out_valid_nxt;
    logic          r_out_parity, w_out_parity_nxt;
    logic [BW-1:0] r_out_beats, w_out_beats_nxt;
    logic          r_ovf_err, w_ovf_err_nxt;

    logic          w_first, w_accept, w_acc_beat, w_mode_eff, w_hit_max, w_term;
    logic [BW-1:0] w_count_beat;

    // Values as they would be after folding in the beat currently offered
    always_comb begin
        w_first      = (r_state == c_IDLE);
        w_accept     = in_valid && (r_state != c_HOLD);
        w_acc_beat   = (w_first ? 1'b0 : r_acc) ^ (^in_data);
        w_count_beat = (w_first ? '0 : r_count) + c_ONE;
        w_mode_eff   = w_first ? odd_mode : r_mode;
        w_hit_max    = (w_count_beat == c_MAX);
        w_term       = w_accept && (in_last || w_hit_max);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_count_nxt      = r_count;
        w_mode_nxt       = r_mode;
        w_out_valid_nxt  = r_out_valid;
        w_out_parity_nxt = r_out_parity;
        w_out_beats_nxt  = r_out_beats;
        w_ovf_err_nxt    = r_ovf_err;
        case (r_state)
            c_IDLE, c_ACC: begin
                if (w_accept) begin
                    w_acc_nxt   = w_acc_beat;
                    w_count_nxt = w_count_beat;
                    w_mode_nxt  = w_mode_eff;
                    if (w_term) begin
                        w_out_valid_nxt  = 1'b1;
                        w_out_parity_nxt = w_acc_beat ^ w_mode_eff;
                        w_out_beats_nxt  = w_count_beat;
                        w_ovf_err_nxt    = w_hit_max && !in_last;
                        w_state_nxt      = c_HOLD;
                    end else begin
                        w_state_nxt = c_ACC;
                    end
                end
            end
            c_HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_acc_nxt       = 1'b0;
                    w_count_nxt     = '0;
                    w_state_nxt     = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_acc        <= 1'b0;
            r_count      <= '0;
            r_mode       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_parity <= 1'b0;
            r_out_beats  <= '0;
            r_ovf_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_count      <= w_count_nxt;
            r_mode       <= w_mode_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_parity <= w_out_parity_nxt;
            r_out_beats  <= w_out_beats_nxt;
            r_ovf_err    <= w_ovf_err_nxt;
        end
    end

    assign in_ready   = (r_state != c_HOLD);
    assign out_valid  = r_out_valid;
    assign out_parity = r_out_parity;
    assign out_beats  = r_out_beats;
    assign ovf_err    = r_ovf_err;

`ifdef PARITY_CHECK_EN
    logic       r_chk_err;
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_err <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_term) begin
                r_chk_err <= (w_acc_beat ^ w_mode_eff) != in_parity;
            end
            if (r_out_valid && out_ready && r_chk_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign chk_err = r_chk_err;
    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_parity_frame_gen                                             |
// | Brief    : directed table-driven bench for parity_frame_gen                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_parity_frame_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       odd_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_parity;
    logic [4:0] out_beats;
    logic       ovf_err;
    logic       in_parity = 1'b0;
    logic       chk_err;
    logic [7:0] err_cnt;

    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_in_data = 8'h00;
    logic       b_in_last = 1'b0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic       b_out_parity;
    logic [0:0] b_out_beats;
    logic       b_ovf_err;
    logic       b_chk_err;
    logic [7:0] b_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    parity_frame_gen #(.WIDTH(8), .MAX_BEATS(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
        .out_beats(out_beats), .ovf_err(ovf_err)
`ifdef PARITY_CHECK_EN
        , .in_parity(in_parity), .chk_err(chk_err), .err_cnt(err_cnt)
`endif
    );

    parity_frame_gen #(.WIDTH(8), .MAX_BEATS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .odd_mode(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_parity(b_out_parity),
        .out_beats(b_out_beats), .ovf_err(b_ovf_err)
`ifdef PARITY_CHECK_EN
        , .in_parity(1'b0), .chk_err(b_chk_err), .err_cnt(b_err_cnt)
`endif
    );

`ifndef PARITY_CHECK_EN
    assign chk_err   = 1'b0;
    assign err_cnt   = 8'd0;
    assign b_chk_err = 1'b0;
    assign b_err_cnt = 8'd0;
`endif

    typedef struct {
        logic            mode;
        int              nb;
        logic [3:0][7:0] d;
        logic            par;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic m);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = m;
    endtask

    // Ends the beat stream; returns at the negedge after the last beat was clocked.
    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string nm, input int par, input int nb, input int ovf);
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_parity"}, int'(out_parity), par);
        chk({nm, "_beats"}, int'(out_beats), nb);
        chk({nm, "_ovf"}, int'(ovf_err), ovf);
        chk({nm, "_in_ready"}, int'(in_ready), 0);
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_hs_valid"}, int'(out_valid), 0);
        chk({nm, "_hs_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        vt[0] = '{1'b0, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, 1'b0};
        vt[1] = '{1'b1, 3, {8'h00, 8'h07, 8'h03, 8'h01}, 1'b1};
        vt[2] = '{1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h01}, 1'b1};
        vt[3] = '{1'b1, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1};
        vt[4] = '{1'b0, 2, {8'h00, 8'h00, 8'hFE, 8'hFF}, 1'b1};
        vt[5] = '{1'b1, 2, {8'h00, 8'h00, 8'h00, 8'h80}, 1'b0};
        vt[6] = '{1'b0, 4, {8'h00, 8'h01, 8'hF0, 8'h0F}, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_parity", int'(out_parity), 0);
        chk("rst_out_beats", int'(out_beats), 0);
        chk("rst_ovf_err", int'(ovf_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;

        // Table frames; odd_mode is flipped after the first beat and must be ignored
        for (int v = 0; v < 7; v++) begin
            in_parity = vt[v].par;
            for (int b = 0; b < vt[v].nb; b++) begin
                beat(vt[v].d[b], (b == vt[v].nb - 1), (b == 0) ? vt[v].mode : ~vt[v].mode);
            end
            settle();
            check_result($sformatf("vec%0d", v), int'(vt[v].par), vt[v].nb, 0);
`ifdef PARITY_CHECK_EN
            chk($sformatf("vec%0d_chk_err", v), int'(chk_err), 0);
`endif
            handshake($sformatf("vec%0d", v));
        end

        // Backpressure: result holds and offered beats are refused
        beat(8'h3C, 1'b1, 1'b0);
        settle();
        check_result("bp0", 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            in_last  = 1'b1;
            odd_mode = 1'b1;
            @(negedge clk);
            check_result($sformatf("bp_hold%0d", i), 0, 1, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake("bp");
        beat(8'h07, 1'b1, 1'b0);
        settle();
        check_result("bp_next", 1, 1, 0);
        handshake("bp_next");

        // Overflow at MAX_BEATS without in_last
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) begin
                chk("ovf_pre_valid", int'(out_valid), 0);
                chk("ovf_pre_in_ready", int'(in_ready), 1);
            end
            in_valid = 1'b1;
            in_data  = 8'h80;
            in_last  = 1'b0;
            odd_mode = 1'b0;
        end
        settle();
        check_result("ovf", 0, 16, 1);
        handshake("ovf");
        beat(8'h80, 1'b1, 1'b0);
        settle();
        check_result("ovf_next", 1, 1, 0);
        handshake("ovf_next");

        // Reset in the middle of a frame
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'h01, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        in_parity = 1'b1;
        beat(8'h01, 1'b1, 1'b0);
        settle();
        check_result("midrst_next", 1, 1, 0);
        handshake("midrst_next");

        // MAX_BEATS = 1: every beat is a frame
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = 8'hA5;
        b_in_last  = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("mb1_a_valid", int'(b_out_valid), 1);
        chk("mb1_a_parity", int'(b_out_parity), 0);
        chk("mb1_a_beats", int'(b_out_beats), 1);
        chk("mb1_a_ovf", int'(b_ovf_err), 1);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk("mb1_hs_valid", int'(b_out_valid), 0);
        b_in_valid = 1'b1;
        b_in_data  = 8'h01;
        b_in_last  = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        chk("mb1_b_valid", int'(b_out_valid), 1);
        chk("mb1_b_parity", int'(b_out_parity), 1);
        chk("mb1_b_ovf", int'(b_ovf_err), 0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;

`ifdef PARITY_CHECK_EN
        // Checker: mismatching in_parity counts on handshake, saturating at 255
        chk("chk_cnt0", int'(err_cnt), 0);
        in_parity = 1'b1;
        beat(8'h03, 1'b1, 1'b0);
        settle();
        chk("chk_err_set", int'(chk_err), 1);
        chk("chk_cnt_before_hs", int'(err_cnt), 0);
        handshake("chk1");
        chk("chk_cnt1", int'(err_cnt), 1);
        in_parity = 1'b0;
        beat(8'h03, 1'b1, 1'b0);
        settle();
        chk("chk_err_clr", int'(chk_err), 0);
        handshake("chk2");
        chk("chk_cnt_same", int'(err_cnt), 1);
        in_parity = 1'b1;
        for (int i = 0; i < 300; i++) begin
            beat(8'h03, 1'b1, 1'b0);
            settle();
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("chk_cnt_sat", int'(err_cnt), 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
